// File: rtl/tcb_lite_arbiter.sv
// ----------------------------------------------------------------------------
// tcb_lite_arbiter
//
// Round-robin arbiter that shares one TCB lite subordinate between MPN TCB
// lite managers. The request fields of the selected manager are multiplexed
// onto the subordinate port. A manager may hold the bus across several
// transfers by setting lck. The response is steered back to the manager that
// issued the transfer, DLY cycles later, by a delay line of grant indices.
//
// Handshake: a transfer happens in every cycle where valid and ready are both
// high. Valid must not depend on ready. Once a manager is stalled (valid high,
// ready low), it keeps the grant until its transfer completes.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   man_vld/man_rdy     per-manager request handshake
//   man_lck/ndn/wen     per-manager lock, endianness, write enable
//   man_adr/siz/byt/wdt per-manager address, size, byte enable, write data
//   man_rdt/man_err     per-manager response (read data, bus error)
//   sub_vld/sub_rdy     subordinate request handshake
//   sub_lck ... sub_wdt multiplexed request fields
//   sub_rdt/sub_err     subordinate response
// ----------------------------------------------------------------------------
module tcb_lite_arbiter #(
   parameter int unsigned MPN = 2,
   parameter int unsigned DLY = 1,
   parameter int unsigned DAT = 32,
   parameter int unsigned ADR = 32,
   parameter int unsigned SIZ = $clog2(DAT/8)
) (
   input  logic                     clk,
   input  logic                     rst,
   // managers
   input  logic [MPN-1:0]           man_vld,
   output logic [MPN-1:0]           man_rdy,
   input  logic [MPN-1:0]           man_lck,
   input  logic [MPN-1:0]           man_ndn,
   input  logic [MPN-1:0]           man_wen,
   input  logic [MPN-1:0][ADR-1:0]  man_adr,
   input  logic [MPN-1:0][SIZ-1:0]  man_siz,
   input  logic [MPN-1:0][DAT/8-1:0] man_byt,
   input  logic [MPN-1:0][DAT-1:0]  man_wdt,
   output logic [MPN-1:0][DAT-1:0]  man_rdt,
   output logic [MPN-1:0]           man_err,
   // subordinate
   output logic                     sub_vld,
   input  logic                     sub_rdy,
   output logic                     sub_lck,
   output logic                     sub_ndn,
   output logic                     sub_wen,
   output logic [ADR-1:0]           sub_adr,
   output logic [SIZ-1:0]           sub_siz,
   output logic [DAT/8-1:0]         sub_byt,
   output logic [DAT-1:0]           sub_wdt,
   input  logic [DAT-1:0]           sub_rdt,
   input  logic                     sub_err
);

   localparam int unsigned IDW = $clog2(MPN);

   // arbitration state
   logic [IDW-1:0] ptr_q, ptr_d;   // last granted manager
   logic           lck_q, lck_d;   // lock active
   logic [IDW-1:0] own_q, own_d;   // lock owner
   logic           stl_q, stl_d;   // previous cycle was a stall
   logic [IDW-1:0] sel_q, sel_d;   // selection held across a stall

   logic [IDW-1:0] sel_rr;
   logic [IDW-1:0] sel;
   logic           trn;

   // Round-robin search starting at ptr+1, wrapping at MPN-1. The last
   // candidate visited is ptr itself. With nobody valid, ptr is kept.
   always_comb begin
      logic [IDW-1:0] cand;
      logic           found;
      sel_rr = ptr_q;
      cand   = ptr_q;
      found  = 1'b0;
      for (int k = 0; k < MPN; k++) begin
         cand = (cand == IDW'(MPN-1)) ? '0 : cand + IDW'(1);
         if (!found && man_vld[cand]) begin
            sel_rr = cand;
            found  = 1'b1;
         end
      end
   end

   // A stalled request keeps its grant. A lock pins the grant to its owner.
   always_comb begin
      if (stl_q)      sel = sel_q;
      else if (lck_q) sel = own_q;
      else            sel = sel_rr;
   end

   // request multiplexer
   always_comb begin
      sub_vld = man_vld[sel];
      sub_lck = man_lck[sel];
      sub_ndn = man_ndn[sel];
      sub_wen = man_wen[sel];
      sub_adr = man_adr[sel];
      sub_siz = man_siz[sel];
      sub_byt = man_byt[sel];
      sub_wdt = man_wdt[sel];
      man_rdy      = '0;
      man_rdy[sel] = sub_rdy;
   end

   assign trn = sub_vld & sub_rdy;

   // next state
   always_comb begin
      stl_d = sub_vld & ~sub_rdy;
      sel_d = sel;
      ptr_d = ptr_q;
      lck_d = lck_q;
      own_d = own_q;
      if (trn) begin
         ptr_d = sel;
         lck_d = man_lck[sel];
         own_d = sel;
      end
   end

   // Reset ptr to the last index, so manager 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= IDW'(MPN-1);
         lck_q <= 1'b0;
         own_q <= '0;
         stl_q <= 1'b0;
         sel_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         lck_q <= lck_d;
         own_q <= own_d;
         stl_q <= stl_d;
         sel_q <= sel_d;
      end
   end

   // response routing
   logic           rsp_trn;
   logic [IDW-1:0] rsp_sel;

   if (DLY > 0) begin : g_dly
      // Entry 0 is one cycle after the transfer; entry DLY-1 is the output.
      logic [DLY-1:0]          dl_trn_q;
      logic [DLY-1:0][IDW-1:0] dl_sel_q;

      // The index only moves along with a live transfer, which keeps idle
      // entries stable.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            dl_trn_q <= '0;
            dl_sel_q <= '0;
         end else begin
            dl_trn_q[0] <= trn;
            if (trn) dl_sel_q[0] <= sel;
            for (int k = 1; k < DLY; k++) begin
               dl_trn_q[k] <= dl_trn_q[k-1];
               if (dl_trn_q[k-1]) dl_sel_q[k] <= dl_sel_q[k-1];
            end
         end
      end

      assign rsp_trn = dl_trn_q[DLY-1];
      assign rsp_sel = dl_sel_q[DLY-1];
   end else begin : g_nodly
      assign rsp_trn = trn;
      assign rsp_sel = sel;
   end

   // Only the manager that owns the returning response sees non-zero data.
   always_comb begin
      man_rdt = '0;
      man_err = '0;
      if (rsp_trn) begin
         man_rdt[rsp_sel] = sub_rdt;
         man_err[rsp_sel] = sub_err;
      end
   end

endmodule
